md_unit: RTL and testbench
==========================

# md_unit

Parametrised multiply/divide unit for the E stage of the pipelined MIPS core. It adds MULT/MULTU/DIV/DIVU/MTHI/MTLO support with configurable latency, a busy handshake and a HI/LO register pair. It is the multi-cycle successor to the single-cycle ALU path. The hazard unit stalls D on `busy`/`start` and on any MFHI/MFLO issued while `busy` is high.

## Interface
- `WIDTH`, 32: operand and HI/LO width.
- `MULT_CYCLES`, 5: busy cycles for MULT/MULTU, ≥1.
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU, ≥1.
- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch operation `op` this cycle.
- `op`  in  3  operation code (md_pkg).
- `a`  in  WIDTH  operand rs (E-stage forwarded value).
- `b`  in  WIDTH  operand rt (E-stage forwarded value).
- `flush`  in  1  abandon in-flight operation; HI/LO keep old values.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse on commit of a mult/div.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- Ops: MULT (signed), MULTU, DIV (signed), DIVU, MTHI, MTLO; other codes are no-ops.
- `start` with `busy`=0: mult/div latches the full result into pending regs, loads the counter with MULT_CYCLES or DIV_CYCLES, and sets `busy`.
- `start` with `busy`=1: ignored, no state change. The stall logic must prevent this; the bench checks that it is ignored.
- MTHI/MTLO with `busy`=0: write `a` to HI/LO at that edge; `busy` stays 0, `done` stays 0.
- Mult: {hi,lo} = a×b at 2·WIDTH bits, signed or unsigned per op.
- Div: lo = quotient, hi = remainder. Signed ops truncate toward zero; the remainder takes the sign of the dividend.
- b=0: lo = all ones, hi = a. Signed MIN/−1: lo = MIN, hi = 0.
- States:
  - IDLE: on valid start of mult/div, go to RUN.
  - RUN: counter decrements each cycle. On counter=1, commit pending to HI/LO, pulse `done`, return to IDLE.
- `flush` in RUN: return to IDLE next edge with no commit and no `done`. `flush` takes priority over a same-cycle commit. `flush` in IDLE: no effect, and a same-cycle `start` is dropped.
- `reset` low at any time: IDLE, counter 0, pending = 0, hi = 0, lo = 0, busy = 0, done = 0.

## Timing
- `start` accepted at edge t. `busy` is 1 for cycles t..t+N−1, where N is the op's latency.
- HI/LO update and `done`=1 at edge t+N. `busy` is 0 after edge t+N.
- Back-to-back: a new `start` is accepted in the cycle after `done`.
- `busy`, `done`, `hi`, `lo` are registered outputs with no combinational path from inputs.
- MTHI/MTLO: single edge, result visible in the next cycle.
- Reset values: all outputs 0.

## Structure
- Package `md_pkg`:
  - op encodings MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5
  - state enum IDLE/RUN
  - counter width function clog2(max(MULT_CYCLES,DIV_CYCLES)+1)
- One sub-module, `md_core`: combinational product/quotient/remainder with the b=0 and overflow rules, parametrised by WIDTH.
- `md_unit` holds the FSM, counter, pending regs and HI/LO.

## Test plan
- MULT a=0xFFFFFFFE (−2), b=3, defaults: busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, single `done` pulse. MULTU with the same operands: hi=0x2, lo=0xFFFFFFFA.
- DIV a=−7, b=2: after 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0: lo=0xFFFFFFFF, hi=7.
- DIV a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0.
- Second `start` (MTHI a=5) while busy: ignored, and HI holds the mult result. MTLO a=0x1234 when idle: lo=0x1234 on the next cycle, busy never rises.
- `flush` on the cycle before commit: busy drops, no `done`, HI/LO unchanged. An immediate restart completes normally.
- Reset asserted mid-RUN with hi/lo nonzero: all outputs 0 asynchronously. After release, a MULT 3×4 gives lo=12 after MULT_CYCLES; repeat with MULT_CYCLES=1, DIV_CYCLES=1.

Source files
------------

// File: rtl/md_pkg.sv
// Shared op encodings, FSM state type and counter sizing for the multiply/divide unit.
package md_pkg;

   localparam int unsigned MD_OP_W = 3;

   localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd0;
   localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd1;
   localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd2;
   localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd3;
   localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd4;
   localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd5;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } md_state_e;

   // Counter must hold the larger of the two latencies.
   function automatic int unsigned md_cnt_w(input int unsigned mult_cycles,
                                            input int unsigned div_cycles);
      int unsigned mx;
      mx = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
      return $clog2(mx + 1);
   endfunction

endpackage

// File: rtl/md_core.sv
// Combinational product / quotient / remainder for MULT, MULTU, DIV, DIVU.
module md_core
   import md_pkg::*;
#(
   parameter int unsigned WIDTH = 32
)(
   input  logic [MD_OP_W-1:0] i_op,
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   output logic [WIDTH-1:0]   o_hi_c,
   output logic [WIDTH-1:0]   o_lo_c
);

   logic [2*WIDTH-1:0] w_prod_s;
   logic [2*WIDTH-1:0] w_prod_u;
   logic               w_sdiv;
   logic               w_neg_a;
   logic               w_neg_b;
   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic [WIDTH-1:0]   w_div_b;
   logic [WIDTH-1:0]   w_quo_u;
   logic [WIDTH-1:0]   w_rem_u;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;

   assign w_prod_s = $signed({{WIDTH{i_a[WIDTH-1]}}, i_a}) * $signed({{WIDTH{i_b[WIDTH-1]}}, i_b});
   assign w_prod_u = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

   // Sign-magnitude divide; MIN/-1 falls out as quotient MIN, remainder 0.
   assign w_sdiv  = (i_op == MD_DIV);
   assign w_neg_a = w_sdiv & i_a[WIDTH-1];
   assign w_neg_b = w_sdiv & i_b[WIDTH-1];
   assign w_mag_a = w_neg_a ? (WIDTH'(0) - i_a) : i_a;
   assign w_mag_b = w_neg_b ? (WIDTH'(0) - i_b) : i_b;
   assign w_div_b = (w_mag_b == WIDTH'(0)) ? WIDTH'(1) : w_mag_b;
   assign w_quo_u = w_mag_a / w_div_b;
   assign w_rem_u = w_mag_a % w_div_b;
   assign w_quo   = (w_neg_a ^ w_neg_b) ? (WIDTH'(0) - w_quo_u) : w_quo_u;
   assign w_rem   = w_neg_a ? (WIDTH'(0) - w_rem_u) : w_rem_u;

   always_comb begin
      o_hi_c = '0;
      o_lo_c = '0;
      case (i_op)
         MD_MULT:  {o_hi_c, o_lo_c} = w_prod_s;
         MD_MULTU: {o_hi_c, o_lo_c} = w_prod_u;
         MD_DIV, MD_DIVU: begin
            if (i_b == WIDTH'(0)) begin
               o_hi_c = i_a;
               o_lo_c = '1;
            end else begin
               o_hi_c = w_rem;
               o_lo_c = w_quo;
            end
         end
         default: begin
            o_hi_c = '0;
            o_lo_c = '0;
         end
      endcase
   end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers, busy handshake and flush.
module md_unit
   import md_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [MD_OP_W-1:0] op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               flush,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo
);

   localparam int unsigned CW = md_cnt_w(MULT_CYCLES, DIV_CYCLES);

   md_state_e        r_state;
   md_state_e        w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nxt;
   logic [WIDTH-1:0] r_pend_hi;
   logic [WIDTH-1:0] r_pend_lo;
   logic [WIDTH-1:0] w_pend_hi_nxt;
   logic [WIDTH-1:0] w_pend_lo_nxt;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] w_hi_nxt;
   logic [WIDTH-1:0] w_lo_nxt;
   logic             r_busy;
   logic             r_done;
   logic             w_done_nxt;
   logic [WIDTH-1:0] w_core_hi;
   logic [WIDTH-1:0] w_core_lo;
   logic             w_is_mul;
   logic             w_is_div;

   md_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .i_op   (op),
      .i_a    (a),
      .i_b    (b),
      .o_hi_c (w_core_hi),
      .o_lo_c (w_core_lo)
   );

   assign w_is_mul = (op == MD_MULT) || (op == MD_MULTU);
   assign w_is_div = (op == MD_DIV)  || (op == MD_DIVU);

   // Next-state: flush wins over both a same-cycle start and a same-cycle commit.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_pend_hi_nxt = r_pend_hi;
      w_pend_lo_nxt = r_pend_lo;
      w_hi_nxt      = r_hi;
      w_lo_nxt      = r_lo;
      w_done_nxt    = 1'b0;
      case (r_state)
         IDLE: begin
            if (start && !flush) begin
               if (w_is_mul || w_is_div) begin
                  w_state_nxt   = RUN;
                  w_cnt_nxt     = w_is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                  w_pend_hi_nxt = w_core_hi;
                  w_pend_lo_nxt = w_core_lo;
               end else if (op == MD_MTHI) begin
                  w_hi_nxt = a;
               end else if (op == MD_MTLO) begin
                  w_lo_nxt = a;
               end
            end
         end
         RUN: begin
            if (flush) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CW'(1)) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
               w_hi_nxt    = r_pend_hi;
               w_lo_nxt    = r_pend_lo;
               w_done_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_pend_hi <= '0;
         r_pend_lo <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_pend_hi <= w_pend_hi_nxt;
         r_pend_lo <= w_pend_lo_nxt;
         r_hi      <= w_hi_nxt;
         r_lo      <= w_lo_nxt;
         r_busy    <= (w_state_nxt == RUN);
         r_done    <= w_done_nxt;
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: default latencies (dut_a) and single-cycle latencies (dut_b).
module tb_md_unit;
   import md_pkg::*;

   localparam int unsigned WIDTH = 32;

   logic               clk;
   logic               reset;
   logic               start_a;
   logic               start_b;
   logic [MD_OP_W-1:0] op;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               flush;
   logic               busy_a, done_a, busy_b, done_b;
   logic [WIDTH-1:0]   hi_a, lo_a, hi_b, lo_b;

   int n_checks = 0;
   int n_errors = 0;

   md_unit #(.WIDTH(WIDTH), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .op(op), .a(a), .b(b), .flush(flush),
      .busy(busy_a), .done(done_a), .hi(hi_a), .lo(lo_a)
   );

   md_unit #(.WIDTH(WIDTH), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .op(op), .a(a), .b(b), .flush(1'b0),
      .busy(busy_b), .done(done_b), .hi(hi_b), .lo(lo_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic [MD_OP_W-1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      op = o; a = x; b = y; start_a = 1'b1;
      step();
      start_a = 1'b0;
   endtask

   // Called right after launch; ends in the cycle where done is high.
   task automatic run_to_done(input string tag, input int unsigned n,
                              input logic [WIDTH-1:0] eh, input logic [WIDTH-1:0] el);
      chk({tag, " busy_first"}, 32'(busy_a), 32'd1);
      for (int i = 1; i < int'(n); i++) begin
         step();
         chk({tag, " busy_run"}, 32'(busy_a), 32'd1);
         chk({tag, " done_early"}, 32'(done_a), 32'd0);
      end
      step();
      chk({tag, " done"}, 32'(done_a), 32'd1);
      chk({tag, " busy_end"}, 32'(busy_a), 32'd0);
      chk({tag, " hi"}, hi_a, eh);
      chk({tag, " lo"}, lo_a, el);
   endtask

   initial begin
      reset = 1'b0; start_a = 1'b0; start_b = 1'b0; flush = 1'b0;
      op = MD_MULT; a = '0; b = '0;
      step(); step();
      chk("rst busy_a", 32'(busy_a), 32'd0);
      chk("rst done_a", 32'(done_a), 32'd0);
      chk("rst hi_a", hi_a, 32'd0);
      chk("rst lo_a", lo_a, 32'd0);
      chk("rst busy_b", 32'(busy_b), 32'd0);
      chk("rst lo_b", lo_b, 32'd0);
      reset = 1'b1;
      step();

      // Signed multiply -2 * 3
      launch(MD_MULT, 32'hFFFF_FFFE, 32'd3);
      run_to_done("mult", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

      // Back-to-back MULTU with an ignored MTHI issued while busy
      launch(MD_MULTU, 32'hFFFF_FFFE, 32'd3);
      chk("multu done_pulse", 32'(done_a), 32'd0);
      chk("multu busy", 32'(busy_a), 32'd1);
      step();
      op = MD_MTHI; a = 32'd5; start_a = 1'b1;
      step();
      start_a = 1'b0;
      chk("ignored_mthi hi", hi_a, 32'hFFFF_FFFF);
      chk("ignored_mthi busy", 32'(busy_a), 32'd1);
      step(); step();
      chk("multu busy_last", 32'(busy_a), 32'd1);
      chk("multu no_early_done", 32'(done_a), 32'd0);
      step();
      chk("multu done", 32'(done_a), 32'd1);
      chk("multu hi", hi_a, 32'h0000_0002);
      chk("multu lo", lo_a, 32'hFFFF_FFFA);
      step();
      chk("multu done_single", 32'(done_a), 32'd0);

      // Signed divide -7 / 2
      launch(MD_DIV, 32'hFFFF_FFF9, 32'd2);
      run_to_done("div", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      step();

      // Divide by zero
      launch(MD_DIVU, 32'd7, 32'd0);
      run_to_done("divu0", 10, 32'd7, 32'hFFFF_FFFF);
      step();

      // Signed overflow MIN / -1
      launch(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      run_to_done("divovf", 10, 32'd0, 32'h8000_0000);
      step();

      // MTLO while idle
      launch(MD_MTLO, 32'h0000_1234, 32'd0);
      chk("mtlo lo", lo_a, 32'h0000_1234);
      chk("mtlo hi", hi_a, 32'd0);
      chk("mtlo busy", 32'(busy_a), 32'd0);
      chk("mtlo done", 32'(done_a), 32'd0);
      step();
      chk("mtlo busy_next", 32'(busy_a), 32'd0);

      // Flush in IDLE drops a same-cycle start
      op = MD_MTHI; a = 32'h0000_DEAD; start_a = 1'b1; flush = 1'b1;
      step();
      start_a = 1'b0; flush = 1'b0;
      chk("idle_flush hi", hi_a, 32'd0);
      chk("idle_flush busy", 32'(busy_a), 32'd0);

      // Flush in the cycle before commit
      launch(MD_MULT, 32'd3, 32'd4);
      step(); step(); step(); step();
      chk("flush busy_before", 32'(busy_a), 32'd1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush busy", 32'(busy_a), 32'd0);
      chk("flush done", 32'(done_a), 32'd0);
      chk("flush hi", hi_a, 32'd0);
      chk("flush lo", lo_a, 32'h0000_1234);

      // Immediate restart after flush
      launch(MD_MULT, 32'hFFFF_FFFE, 32'd3);
      chk("restart done_flushed", 32'(done_a), 32'd0);
      run_to_done("restart", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      step();

      // Asynchronous reset mid-run
      launch(MD_DIV, 32'd100, 32'd7);
      step(); step();
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst busy", 32'(busy_a), 32'd0);
      chk("async_rst done", 32'(done_a), 32'd0);
      chk("async_rst hi", hi_a, 32'd0);
      chk("async_rst lo", lo_a, 32'd0);
      step();
      reset = 1'b1;
      step();
      chk("post_rst busy", 32'(busy_a), 32'd0);
      launch(MD_MULT, 32'd3, 32'd4);
      run_to_done("post_rst_mult", 5, 32'd0, 32'd12);
      step();

      // Single-cycle latency instance
      op = MD_MULT; a = 32'd3; b = 32'd4; start_b = 1'b1;
      step();
      start_b = 1'b0;
      chk("b1 busy", 32'(busy_b), 32'd1);
      chk("b1 done_early", 32'(done_b), 32'd0);
      step();
      chk("b1 done", 32'(done_b), 32'd1);
      chk("b1 busy_end", 32'(busy_b), 32'd0);
      chk("b1 lo", lo_b, 32'd12);
      chk("b1 hi", hi_b, 32'd0);

      op = MD_DIVU; a = 32'd100; b = 32'd7; start_b = 1'b1;
      step();
      start_b = 1'b0;
      chk("b1 divu busy", 32'(busy_b), 32'd1);
      chk("b1 divu done_low", 32'(done_b), 32'd0);
      step();
      chk("b1 divu done", 32'(done_b), 32'd1);
      chk("b1 divu lo", lo_b, 32'd14);
      chk("b1 divu hi", hi_b, 32'd2);

      op = MD_DIV; a = 32'hFFFF_FF9C; b = 32'd7; start_b = 1'b1;
      step();
      start_b = 1'b0;
      step();
      chk("b1 div lo", lo_b, 32'hFFFF_FFF2);
      chk("b1 div hi", hi_b, 32'hFFFF_FFFE);

      op = MD_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start_b = 1'b1;
      step();
      start_b = 1'b0;
      step();
      chk("b1 multu hi", hi_b, 32'hFFFF_FFFE);
      chk("b1 multu lo", lo_b, 32'h0000_0001);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
